// File: rtl/iq_demod.sv
`timescale 1ns/1ps
// IQ demodulator: mixes ADC samples with NCO cos/sin, sums DEC products per block,
// and hands each block sum downstream over a valid/ready port. Define IQ_DEMOD_SATURATE_EN to clamp.
//
// Output state | meaning
// -------------+-----------------------------------------------
// S_EMPTY      | no unconsumed result, valid_o=0
// S_FULL       | i_o/q_o hold a result awaiting ready_i
module iq_demod #(
  parameter int DEC   = 64,
  parameter int ACC_W = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic signed [15:0]      adc_i,
  input  logic signed [15:0]      cos_i,
  input  logic signed [15:0]      sin_i,
  output logic signed [ACC_W-1:0] i_o,
  output logic signed [ACC_W-1:0] q_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    overrun_o
);

  localparam int CNT_W = (DEC > 1) ? $clog2(DEC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEC - 1);

  typedef enum logic {S_EMPTY, S_FULL} out_state_t;

  logic signed [31:0]      pi;
  logic signed [31:0]      pq;
  logic                    tick_d;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] sum_i;
  logic signed [ACC_W-1:0] sum_q;
  logic signed [ACC_W-1:0] dump_i;
  logic signed [ACC_W-1:0] dump_q;
  logic                    dump_v;
  out_state_t              state_q;
  out_state_t              state_d;
  logic                    load;
  logic                    ovr_set;

  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [31:0] p);
`ifdef IQ_DEMOD_SATURATE_EN
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W-31){p[31]}}, p};
    // A mismatch between the two top bits means the true sum left the ACC_W range.
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
`else
    return a + {{(ACC_W-32){p[31]}}, p};
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      pi     <= '0;
      pq     <= '0;
      tick_d <= 1'b0;
    end else begin
      tick_d <= tick;
      if (tick) begin
        pi <= adc_i * cos_i;
        pq <= adc_i * sin_i;
      end
    end
  end

  always_comb begin
    sum_i = acc_add(acc_i, pi);
    sum_q = acc_add(acc_q, pq);
  end

  // The dump result is staged one cycle so it reaches the output two edges after the last tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_i  <= '0;
      acc_q  <= '0;
      cnt    <= '0;
      dump_i <= '0;
      dump_q <= '0;
      dump_v <= 1'b0;
    end else begin
      dump_v <= 1'b0;
      if (tick_d) begin
        if (cnt == CNT_LAST) begin
          dump_i <= sum_i;
          dump_q <= sum_q;
          dump_v <= 1'b1;
          acc_i  <= '0;
          acc_q  <= '0;
          cnt    <= '0;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          cnt   <= cnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (dump_v) begin
          load    = 1'b1;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (ready_i) begin
          if (dump_v) load = 1'b1;
          else        state_d = S_EMPTY;
        end else if (dump_v) begin
          ovr_set = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_EMPTY;
      i_o       <= '0;
      q_o       <= '0;
      overrun_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        i_o <= dump_i;
        q_o <= dump_q;
      end
      if (ovr_set) overrun_o <= 1'b1;
    end
  end

  assign valid_o = (state_q == S_FULL);

endmodule

// File: tb/tb_iq_demod.sv
`timescale 1ns/1ps
// Self-checking bench for iq_demod (DEC=4, ACC_W=33): scoreboard of expected block sums
// consumed by a transfer monitor, plus per-scenario timing/handshake checks.
module tb_iq_demod;
  localparam int DEC   = 4;
  localparam int ACC_W = 33;

  typedef struct {
    logic signed [ACC_W-1:0] i;
    logic signed [ACC_W-1:0] q;
  } res_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    tick = 1'b0;
  logic signed [15:0]      adc = '0;
  logic signed [15:0]      cosv = '0;
  logic signed [15:0]      sinv = '0;
  logic signed [ACC_W-1:0] i_o;
  logic signed [ACC_W-1:0] q_o;
  logic                    valid_o;
  logic                    ready = 1'b1;
  logic                    overrun_o;

  res_t exp_q[$];
  res_t exp_r;
  int   n_checks = 0;
  int   n_fail   = 0;

  iq_demod #(.DEC(DEC), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .adc_i(adc), .cos_i(cosv), .sin_i(sinv),
    .i_o(i_o), .q_o(q_o), .valid_o(valid_o),
    .ready_i(ready), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  // Transfer monitor: a handshake seen here completes on the following posedge.
  always @(negedge clk) begin
    if (rst && valid_o && ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL transfer_unexpected: got i=%0d q=%0d, required no transfer", i_o, q_o);
      end else begin
        exp_r = exp_q.pop_front();
        if (i_o !== exp_r.i || q_o !== exp_r.q) begin
          n_fail++;
          $display("FAIL transfer_data: got i=%0d q=%0d, required i=%0d q=%0d",
                   i_o, q_o, exp_r.i, exp_r.q);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // n back-to-back ticks; returns 2 time units after the edge sampling the last one.
  task automatic drive_block(input int n, input logic signed [15:0] a,
                             input logic signed [15:0] c, input logic signed [15:0] s);
    step();
    tick = 1'b1; adc = a; cosv = c; sinv = s;
    repeat (n - 1) step();
    step();
    tick = 1'b0;
  endtask

  task automatic push(input logic signed [ACC_W-1:0] i, input logic signed [ACC_W-1:0] q);
    res_t r;
    r.i = i; r.q = q;
    exp_q.push_back(r);
  endtask

  task automatic test_reset();
    rst = 1'b0; tick = 1'b1; adc = 16'sd1; cosv = 16'sd1; sinv = 16'sd0;
    repeat (3) step();
    n_checks++; if (i_o !== '0)       begin n_fail++; $display("FAIL reset_i: got %0d, required 0", i_o); end
    n_checks++; if (q_o !== '0)       begin n_fail++; $display("FAIL reset_q: got %0d, required 0", q_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", valid_o); end
    n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, required 0", overrun_o); end
    rst = 1'b1; tick = 1'b0;
    drive_block(3, 16'sd1, 16'sd1, 16'sd0);
    repeat (5) step();
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_tick_ignored: got valid=%b, required 0", valid_o); end
    push(33'sd4, 33'sd0);
    drive_block(1, 16'sd1, 16'sd1, 16'sd0);
    for (int k = 0; k < 20 && valid_o !== 1'b1; k++) step();
    n_checks++;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL reset_first_block: got valid=%b, required 1", valid_o); end
    for (int k = 0; k < 20 && valid_o !== 1'b0; k++) step();
  endtask

  task automatic test_basic();
    ready = 1'b1;
    push(33'sd400000, 33'sd0);
    drive_block(4, 16'sd100, 16'sd1000, 16'sd0);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_lat0: got valid=%b, required 0", valid_o); end
    step();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_lat1: got valid=%b, required 0", valid_o); end
    step();
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_lat2: got valid=%b, required 1", valid_o); end
    step();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_drop: got valid=%b, required 0", valid_o); end
  endtask

  task automatic test_negative();
    ready = 1'b1;
    push(33'sd0, -33'sd24);
    drive_block(4, -16'sd2, 16'sd0, 16'sd3);
    for (int k = 0; k < 20 && valid_o !== 1'b1; k++) step();
    n_checks++;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL negative_timeout: got valid=%b, required 1", valid_o); end
    for (int k = 0; k < 20 && valid_o !== 1'b0; k++) step();
  endtask

  task automatic test_back_to_back();
    ready = 1'b0;
    push(33'sd36, -33'sd12);
    drive_block(4, 16'sd3, 16'sd3, -16'sd1);
    for (int k = 0; k < 20 && valid_o !== 1'b1; k++) step();
    n_checks++;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_first_timeout: got valid=%b, required 1", valid_o); end
    push(-33'sd80, -33'sd32);
    drive_block(4, -16'sd4, 16'sd5, 16'sd2);
    step();
    ready = 1'b1;
    step();
    n_checks++; if (valid_o !== 1'b1)   begin n_fail++; $display("FAIL b2b_valid: got %b, required 1", valid_o); end
    n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b, required 0", overrun_o); end
    n_checks++; if (i_o !== -33'sd80)   begin n_fail++; $display("FAIL b2b_new_i: got %0d, required -80", i_o); end
    for (int k = 0; k < 20 && valid_o !== 1'b0; k++) step();
  endtask

  task automatic test_overrun();
    ready = 1'b0;
    push(33'sd40, -33'sd60);
    drive_block(4, 16'sd5, 16'sd2, -16'sd3);
    for (int k = 0; k < 20 && valid_o !== 1'b1; k++) step();
    n_checks++;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL overrun_first_timeout: got valid=%b, required 1", valid_o); end
    drive_block(4, 16'sd7, 16'sd1, 16'sd1);
    repeat (3) step();
    n_checks++; if (valid_o !== 1'b1)   begin n_fail++; $display("FAIL overrun_hold_valid: got %b, required 1", valid_o); end
    n_checks++; if (i_o !== 33'sd40)    begin n_fail++; $display("FAIL overrun_hold_i: got %0d, required 40", i_o); end
    n_checks++; if (q_o !== -33'sd60)   begin n_fail++; $display("FAIL overrun_hold_q: got %0d, required -60", q_o); end
    n_checks++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b, required 1", overrun_o); end
    ready = 1'b1;
    step();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL overrun_after_xfer: got valid=%b, required 0", valid_o); end
    repeat (4) step();
    n_checks++; if (valid_o !== 1'b0)   begin n_fail++; $display("FAIL overrun_single_xfer: got valid=%b, required 0", valid_o); end
    n_checks++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b, required 1", overrun_o); end
  endtask

  task automatic test_reset_mid();
    ready = 1'b1;
    drive_block(2, 16'sd9, 16'sd9, 16'sd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_overrun: got %b, required 0", overrun_o); end
    push(33'sd4, 33'sd0);
    drive_block(4, 16'sd1, 16'sd1, 16'sd0);
    for (int k = 0; k < 20 && valid_o !== 1'b1; k++) step();
    n_checks++;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_timeout: got valid=%b, required 1", valid_o); end
    for (int k = 0; k < 20 && valid_o !== 1'b0; k++) step();
  endtask

  task automatic test_saturate();
    ready = 1'b1;
`ifdef IQ_DEMOD_SATURATE_EN
    push(33'h0_FFFF_FFFF, 33'sd0);
`else
    push(33'h1_0000_0000, 33'sd0);
`endif
    drive_block(4, -16'sd32768, -16'sd32768, 16'sd0);
    for (int k = 0; k < 20 && valid_o !== 1'b1; k++) step();
    n_checks++;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL saturate_timeout: got valid=%b, required 1", valid_o); end
    for (int k = 0; k < 20 && valid_o !== 1'b0; k++) step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_saturate();
    repeat (5) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending results, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iq_demod.md
IQ_DEMOD -- requirements
Module: iq_demod

Interface
REQ-001 SHALL have parameter DEC, default 64, meaning the number of ticked samples per output (legal range 2..1024).
REQ-002 SHALL have parameter ACC_W, default 48, meaning the accumulator and output width in bits (legal range 33..64).
REQ-003 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port tick  input  1  sample strobe shared with the upstream NCO/CORDIC.
REQ-006 SHALL have port adc_i  input  16  signed ADC sample.
REQ-007 SHALL have port cos_i  input  16  signed NCO cosine.
REQ-008 SHALL have port sin_i  input  16  signed NCO sine.
REQ-009 SHALL have port i_o  output  ACC_W  signed in-phase block sum.
REQ-010 SHALL have port q_o  output  ACC_W  signed quadrature block sum.
REQ-011 SHALL have port valid_o  output  1  i_o and q_o hold an unconsumed result.
REQ-012 SHALL have port ready_i  input  1  downstream accepts the result.
REQ-013 SHALL have port overrun_o  output  1  sticky flag: a result was dropped.

Function
REQ-014 SHALL register, in the cycle after a clk edge with tick=1, the products pi=adc_i*cos_i and pq=adc_i*sin_i (32-bit signed) plus a delayed strobe tick_d.
REQ-015 SHALL, on tick_d=1, sign-extend pi and pq to ACC_W and add them to accumulators acc_i and acc_q, and increment sample counter cnt (0..DEC-1).
REQ-016 SHALL, on tick_d=1 with cnt=DEC-1, form the dump: (acc_i+pi, acc_q+pq) becomes the block result, acc_i/acc_q load 0, and cnt wraps to 0.
REQ-017 SHALL present the block result at i_o/q_o with valid_o=1 on the clk edge after the dump; this is 2 cycles after the edge sampling the DEC-th tick.
REQ-018 SHALL complete a transfer on any edge with valid_o=1 and ready_i=1; valid_o then drops unless a dump occurs on the same edge.
REQ-019 SHALL hold i_o, q_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-020 SHALL, on a dump with valid_o=1 and ready_i=1, load the new result, keep valid_o=1 and leave overrun_o unchanged.
REQ-021 SHALL, on a dump with valid_o=1 and ready_i=0, discard the new result, keep the old one and set overrun_o=1.
REQ-022 SHALL keep overrun_o=1 until reset.
REQ-023 SHALL ignore ticks arriving on consecutive cycles in no way: each tick is one sample.
REQ-024 SHALL wrap accumulator arithmetic modulo 2^ACC_W unless the macro in REQ-029 is defined.

Reset
REQ-025 SHALL, on an edge with rst=0, clear acc_i, acc_q, cnt, the product registers, tick_d, i_o, q_o, valid_o and overrun_o to 0.
REQ-026 SHALL, on reset mid-block, discard the partial sum, and the first sample after reset release SHALL count as sample 0.
REQ-027 SHALL ignore a tick sampled on an edge where rst=0.
REQ-028 SHALL keep valid_o=0 until the first full block after reset completes.

Configuration
REQ-029 SHALL, with IQ_DEMOD_SATURATE_EN defined, clamp each accumulator update (including the dump sum) to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-030 SHALL, without IQ_DEMOD_SATURATE_EN, contain no clamp logic and wrap per REQ-024.

Verification
REQ-031 SHALL check: DEC=4; adc=100, cos=1000, sin=0; 4 ticks -> i_o=400000, q_o=0, valid_o rises 2 cycles after the 4th tick edge.
REQ-032 SHALL check: DEC=4; adc=-2, cos=0, sin=3; 4 ticks -> q_o=-24, i_o=0.
REQ-033 SHALL check: ready_i=0 held across two blocks -> the first result is held, the second is dropped, overrun_o=1; then ready_i=1 -> one transfer, valid_o=0.
REQ-034 SHALL check: ready_i=1 with a dump on the same edge as a transfer -> valid_o stays 1, the new values load, overrun_o=0.
REQ-035 SHALL check: rst=0 after 2 of 4 ticks, then release and 4 ticks of adc=1, cos=1 -> i_o=4, not 6.
REQ-036 SHALL check, with IQ_DEMOD_SATURATE_EN: ACC_W=33, DEC=4, adc=-32768, cos=-32768 -> i_o=4294967295; without the macro -> i_o=-4294967296 (wrapped).
